// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package sub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int unsigned nibbles(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

  // Counter width for idx; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    return (nibbles(width) > 1) ? $clog2(nibbles(width)) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder: {cout, s} = x + y + cin.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is a flat sum of products of g/p and cin; no ripple path.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial a - b - bin, one nibble per clock through a shared CLA slice.
// Define SUBTRACTOR_OVF_EN to compile in signed-overflow detection on ovf.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = nibbles(WIDTH);
  localparam int unsigned IDX_W   = idx_width(WIDTH);

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic [WIDTH-1:0]   diff_q, diff_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               c_q, c_n;
  logic               bout_q, bout_n;
  logic               in_ready_q, in_ready_n;
  logic               out_valid_q, out_valid_n;
`ifdef SUBTRACTOR_OVF_EN
  logic               ovf_q, ovf_n;
`endif

  int unsigned        lo;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic               cout;
  logic               last_nib;

  // Operand nibble select for the current step.
  always_comb begin
    lo    = 32'(idx_q) * NIBBLE_W;
    a_nib = a_q[lo +: NIBBLE_W];
    b_nib = b_q[lo +: NIBBLE_W];
  end

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // Subtraction as a + ~b + carry, where the carry holds the inverted borrow.
  cla4_slice u_slice (
    .x    (a_nib),
    .y    (~b_nib),
    .cin  (c_q),
    .s    (s_nib),
    .cout (cout)
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      idx_q       <= '0;
      c_q         <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUBTRACTOR_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      a_q         <= a_n;
      b_q         <= b_n;
      diff_q      <= diff_n;
      idx_q       <= idx_n;
      c_q         <= c_n;
      bout_q      <= bout_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
`ifdef SUBTRACTOR_OVF_EN
      ovf_q       <= ovf_n;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    diff_n  = diff_q;
    idx_n   = idx_q;
    c_n     = c_q;
    bout_n  = bout_q;
`ifdef SUBTRACTOR_OVF_EN
    ovf_n   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_n     = a;
          b_n     = b;
          c_n     = ~bin;
          idx_n   = '0;
          state_n = RUN;
        end
      end

      RUN: begin
        diff_n[lo +: NIBBLE_W] = s_nib;
        c_n = cout;
        if (last_nib) begin
          idx_n   = '0;
          bout_n  = ~cout;
`ifdef SUBTRACTOR_OVF_EN
          // Operands of differing sign whose result sign departs from a.
          ovf_n   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
          state_n = DONE;
        end else begin
          idx_n = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUBTRACTOR_OVF_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16), directed vectors.
module tb_nibble_serial_subtractor;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = 4;
`ifdef SUBTRACTOR_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got diff 0x%0h with empty scoreboard", diff);
      end else begin
        mon_e = sb.pop_front();
        chk("diff", 32'(diff), 32'(mon_e.diff));
        chk("bout", 32'(bout), 32'(mon_e.bout));
        chk("ovf",  32'(ovf),  32'(mon_e.ovf));
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
  endtask

  // Issue one operation, queue its expectation and measure accept-to-valid latency.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input logic eo_if_en);
    int lat = 0;
    wait_ready();
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    sb.push_back('{diff: ed, bout: eb, ovf: (OVF_EN & eo_if_en)});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(NIB));
    if (out_ready) begin
      @(negedge clk);
      chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_diff"},      32'(diff),      32'd0);
    chk({tag, "_bout"},      32'(bout),      32'd0);
    chk({tag, "_ovf"},       32'(ovf),       32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Basic and boundary vectors.
    issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    issue(16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0);
    issue(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Backpressure: result held, stray in_valid pulses ignored.
    out_ready = 1'b0;
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_diff",      32'(diff),      32'h7FFF);
      chk("bp_bout",      32'(bout),      32'd0);
      chk("bp_ovf",       32'(ovf),       32'(OVF_EN));
      a        = 16'hFFFF;
      b        = 16'h0001;
      in_valid = (i % 2 == 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_no_stray_op", 32'(out_valid), 32'd0);
    end

    // Reset mid-operation, while idx = 2.
    wait_ready();
    a        = 16'h1234;
    b        = 16'h0234;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    issue(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor computing diff = a − b − bin one 4-bit nibble per clock, LSB nibble first, through a single 4-bit carry-lookahead slice with a registered borrow chain. Inverse-direction companion to the team's 4-bit CLA adder. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Trades latency for area against a flat WIDTH-bit subtractor.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of 4 and ≥ 8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff, bout, ovf are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a − b − bin, mod 2^WIDTH.
- bout  output  1  borrow-out; 1 when the unsigned a < b + bin.
- ovf  output  1  two's-complement signed overflow (see Configuration).

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: nibble counter idx runs 0 .. NIBBLES−1, with NIBBLES = WIDTH/4.
  - DONE: out_valid=1.
- IDLE → RUN on in_valid && in_ready.
  - a, b latched; carry register c ← ~bin; idx ← 0.
- RUN, each cycle:
  - The slice computes {c', s} = a[idx] + ~b[idx] + c.
  - s is written into diff nibble idx, c ← c', idx ← idx+1.
  - After the edge that processes idx = NIBBLES−1, the state moves to DONE.
- DONE:
  - bout = ~c.
  - ovf = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]).
  - All outputs held stable until out_ready. On out_valid && out_ready the state returns to IDLE.
- in_ready is low in RUN and DONE. Inputs are ignored outside IDLE. There is no result/operand overlap.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, idx=0, c=0.
- Reset in RUN or DONE aborts the operation. The in-flight result is discarded and never presented.
- The arithmetic carries no extra width: overflow is reported only by bout and ovf, and diff wraps modulo 2^WIDTH.

## Timing
- Accept at edge T. out_valid rises at edge T+NIBBLES (4 cycles for WIDTH=16).
- Result handshake at edge R: out_valid falls and in_ready rises at R. The earliest next accept is edge R+1.
- Minimum cycles per operation: NIBBLES+2.
- out_ready held low: out_valid, diff, bout and ovf stay constant indefinitely.
- in_valid asserted while in_ready=0: no effect, no state change.
- Interior diff nibbles are not observable as valid before DONE. diff is only meaningful while out_valid=1.

## Configuration
- SUBTRACTOR_OVF_EN:
  - Defined: the ovf logic is compiled in and computed as above in DONE.
  - Undefined: ovf is tied to 0 and the overflow logic is absent. The port remains so the interface does not change.

## Structure
- Shared package sub_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the constant NIBBLE_W = 4;
  - a localparam function for NIBBLES and the idx width, $clog2(NIBBLES).
- One sub-module, cla4_slice: a combinational 4-bit carry-lookahead adder with generate/propagate terms.
  - Ports: x[3:0], y[3:0], cin → s[3:0], cout.
  - The top level feeds it y = ~b nibble.

## Test plan
- a=0x1234, b=0x0234, bin=0 → out_valid 4 cycles after accept; diff=0x1000, bout=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. Borrow ripples through all nibbles.
- a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0.
  - ovf=1 with SUBTRACTOR_OVF_EN defined.
  - ovf=0 without it.
- a=0x0010, b=0x0000, bin=1 → diff=0x000F, bout=0.
  - a=0x0000, b=0x0000, bin=1 → diff=0xFFFF, bout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0.
  - in_valid pulses in that window are ignored.
  - Raising out_ready gives in_ready=1 the next cycle.
- Assert rst for one cycle during RUN (idx=2).
  - Next cycle: IDLE, out_valid=0, all outputs 0.
  - A new operation 0x0005−0x0003 then yields diff=0x0002, bout=0.
